// File: rtl/pc_unit_param.sv
// Parametrised MIPS32 fetch-stage program counter: sequential/branch/jump/exception
// next-PC selection with stall support and a priority buffer for redirects seen while stalled.
module pc_unit_param #(
    parameter int          PC_WIDTH     = 32,
    parameter int          STEP         = 4,
    parameter int          ALIGN_BITS   = 2,
    parameter logic [31:0] RESET_VECTOR = 32'h0,
    parameter logic [31:0] EXC_VECTOR   = 32'h80
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump_en,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                exc_en,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [PC_WIDTH-1:0] npc_out,
    output logic                fetch_valid,
    output logic                redirect_pend,
    output logic                misalign_err
);

    typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

    localparam logic [1:0] PRI_NONE   = 2'd0;
    localparam logic [1:0] PRI_BRANCH = 2'd1;
    localparam logic [1:0] PRI_JUMP   = 2'd2;
    localparam logic [1:0] PRI_EXC    = 2'd3;

    localparam logic [PC_WIDTH-1:0] RST_PC     = PC_WIDTH'(RESET_VECTOR);
    localparam logic [PC_WIDTH-1:0] EXC_PC     = PC_WIDTH'(EXC_VECTOR);
    localparam logic [PC_WIDTH-1:0] STEP_W     = PC_WIDTH'(STEP);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    state_t              state;
    state_t              state_next;
    logic [PC_WIDTH-1:0] pc;
    logic [1:0]          pend_pri;
    logic [PC_WIDTH-1:0] pend_target;
    logic                err;

    logic [1:0]          live_pri;
    logic [PC_WIDTH-1:0] live_target;
    logic [1:0]          sel_pri;
    logic [PC_WIDTH-1:0] sel_target;
    logic [PC_WIDTH-1:0] npc;
    logic                npc_misalign;
    logic                advance;
    logic                buffer_write;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            BOOT:    state_next = RUN;
            RUN:     state_next = stall ? STALL : RUN;
            STALL:   state_next = stall ? STALL : RUN;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        fetch_valid = (state == RUN);
    end

    always_comb begin
        live_pri    = PRI_NONE;
        live_target = '0;
        if (exc_en) begin
            live_pri = PRI_EXC;
        end else if (jump_en) begin
            live_pri    = PRI_JUMP;
            live_target = jump_target;
        end else if (branch_taken) begin
            live_pri    = PRI_BRANCH;
            live_target = branch_target;
        end
    end

    // A buffered redirect only wins when strictly higher; ties go to the live request.
    always_comb begin
        sel_pri    = live_pri;
        sel_target = live_target;
        if (pend_pri > live_pri) begin
            sel_pri    = pend_pri;
            sel_target = pend_target;
        end
        npc          = pc + STEP_W;
        npc_misalign = 1'b0;
        unique case (sel_pri)
            PRI_EXC: npc = EXC_PC;
            PRI_JUMP, PRI_BRANCH: begin
                npc          = sel_target & ~ALIGN_MASK;
                npc_misalign = |(sel_target & ALIGN_MASK);
            end
            default: npc = pc + STEP_W;
        endcase
    end

    always_comb begin
        advance      = (state != BOOT) && !stall;
        buffer_write = (state != BOOT) && stall && (live_pri != PRI_NONE) && (live_pri >= pend_pri);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= RST_PC;
            pend_pri    <= PRI_NONE;
            pend_target <= '0;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            if (advance) begin
                pc          <= npc;
                pend_pri    <= PRI_NONE;
                pend_target <= '0;
                err         <= npc_misalign;
            end else if (buffer_write) begin
                pend_pri    <= live_pri;
                pend_target <= live_target;
            end
        end
    end

    assign pc_out        = pc;
    assign npc_out       = npc;
    assign redirect_pend = (pend_pri != PRI_NONE);
    assign misalign_err  = err;

endmodule

// File: tb/tb_pc_unit_param.sv
// Directed bench for pc_unit_param: default, ALIGN_BITS=0 and 10-bit/STEP=1 instances share stimulus.
module tb_pc_unit_param;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        exc_en;

    logic [31:0] m_pc, m_npc, a_pc, a_npc;
    logic [9:0]  s_pc, s_npc;
    logic        m_fv, m_rp, m_me, a_fv, a_rp, a_me, s_fv, s_rp, s_me;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    pc_unit_param u_main (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_en(jump_en), .jump_target(jump_target), .exc_en(exc_en),
        .pc_out(m_pc), .npc_out(m_npc), .fetch_valid(m_fv),
        .redirect_pend(m_rp), .misalign_err(m_me)
    );

    pc_unit_param #(.ALIGN_BITS(0)) u_noalign (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_en(jump_en), .jump_target(jump_target), .exc_en(exc_en),
        .pc_out(a_pc), .npc_out(a_npc), .fetch_valid(a_fv),
        .redirect_pend(a_rp), .misalign_err(a_me)
    );

    pc_unit_param #(.PC_WIDTH(10), .STEP(1), .ALIGN_BITS(0)) u_small (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target[9:0]),
        .jump_en(jump_en), .jump_target(jump_target[9:0]), .exc_en(exc_en),
        .pc_out(s_pc), .npc_out(s_npc), .fetch_valid(s_fv),
        .redirect_pend(s_rp), .misalign_err(s_me)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge, where inputs change and outputs are sampled.
    task automatic apply_stimulus();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_requests();
        branch_taken  = 1'b0;
        jump_en       = 1'b0;
        exc_en        = 1'b0;
        branch_target = '0;
        jump_target   = '0;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        clear_requests();
        apply_stimulus();
        apply_stimulus();

        check_output("rst_pc", m_pc, 32'h0);
        check_output("rst_fv", {31'b0, m_fv}, 32'h0);
        check_output("rst_rp", {31'b0, m_rp}, 32'h0);
        check_output("rst_me", {31'b0, m_me}, 32'h0);

        reset = 1'b0;
        #1;
        check_output("boot_pc", m_pc, 32'h0);
        check_output("boot_fv", {31'b0, m_fv}, 32'h0);
        check_output("boot_npc", m_npc, 32'h4);

        apply_stimulus();
        check_output("run0_pc", m_pc, 32'h0);
        check_output("run0_fv", {31'b0, m_fv}, 32'h1);
        apply_stimulus();
        check_output("run1_pc", m_pc, 32'h4);
        apply_stimulus();
        check_output("run2_pc", m_pc, 32'h8);
        apply_stimulus();
        check_output("run3_pc", m_pc, 32'hC);
        check_output("small_seq_pc", {22'b0, s_pc}, 32'h3);

        apply_stimulus();
        check_output("pc_0x10", m_pc, 32'h10);
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        #1;
        check_output("br_npc", m_npc, 32'h100);
        apply_stimulus();
        check_output("br_pc", m_pc, 32'h100);
        jump_en     = 1'b1;
        jump_target = 32'h200;
        apply_stimulus();
        check_output("jmp_over_br", m_pc, 32'h200);
        exc_en = 1'b1;
        apply_stimulus();
        check_output("exc_over_all", m_pc, 32'h80);
        check_output("exc_no_err", {31'b0, m_me}, 32'h0);

        clear_requests();
        jump_en     = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        apply_stimulus();
        check_output("wrap_pre", m_pc, 32'hFFFF_FFFC);
        clear_requests();
        apply_stimulus();
        check_output("wrap_post", m_pc, 32'h0);
        apply_stimulus();
        check_output("after_wrap", m_pc, 32'h4);

        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        apply_stimulus();
        clear_requests();
        check_output("stl1_pc", m_pc, 32'h4);
        check_output("stl1_fv", {31'b0, m_fv}, 32'h0);
        check_output("stl1_rp", {31'b0, m_rp}, 32'h1);
        apply_stimulus();
        apply_stimulus();
        check_output("stl3_pc", m_pc, 32'h4);
        check_output("stl3_npc", m_npc, 32'h40);
        stall = 1'b0;
        apply_stimulus();
        check_output("rel_pc", m_pc, 32'h40);
        check_output("rel_rp", {31'b0, m_rp}, 32'h0);
        check_output("rel_fv", {31'b0, m_fv}, 32'h1);

        stall       = 1'b1;
        jump_en     = 1'b1;
        jump_target = 32'h300;
        apply_stimulus();
        clear_requests();
        branch_taken  = 1'b1;
        branch_target = 32'h400;
        apply_stimulus();
        clear_requests();
        check_output("buf_keep_jmp", m_npc, 32'h300);
        check_output("buf_pc_held", m_pc, 32'h40);
        exc_en = 1'b1;
        apply_stimulus();
        clear_requests();
        check_output("buf_exc", m_npc, 32'h80);
        stall = 1'b0;
        apply_stimulus();
        check_output("buf_rel_pc", m_pc, 32'h80);
        check_output("buf_rel_rp", {31'b0, m_rp}, 32'h0);

        branch_taken  = 1'b1;
        branch_target = 32'h102;
        apply_stimulus();
        clear_requests();
        check_output("mis_pc", m_pc, 32'h100);
        check_output("mis_err", {31'b0, m_me}, 32'h1);
        check_output("noal_pc", a_pc, 32'h102);
        check_output("noal_err", {31'b0, a_me}, 32'h0);
        apply_stimulus();
        check_output("mis_err_drop", {31'b0, m_me}, 32'h0);
        check_output("mis_next_pc", m_pc, 32'h104);

        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h500;
        apply_stimulus();
        clear_requests();
        check_output("pre_rst_rp", {31'b0, m_rp}, 32'h1);
        check_output("small_pre_rst_rp", {31'b0, s_rp}, 32'h1);
        reset = 1'b1;
        #1;
        check_output("async_rst_pc", m_pc, 32'h0);
        check_output("async_rst_rp", {31'b0, m_rp}, 32'h0);
        check_output("small_rst_pc", {22'b0, s_pc}, 32'h0);
        check_output("small_rst_rp", {31'b0, s_rp}, 32'h0);
        apply_stimulus();
        reset = 1'b0;
        stall = 1'b0;
        #1;
        check_output("reboot_fv", {31'b0, m_fv}, 32'h0);
        check_output("small_reboot_fv", {31'b0, s_fv}, 32'h0);
        apply_stimulus();
        check_output("reboot_run_fv", {31'b0, m_fv}, 32'h1);
        check_output("reboot_run_pc", m_pc, 32'h0);
        check_output("small_run_fv", {31'b0, s_fv}, 32'h1);
        apply_stimulus();
        check_output("reboot_seq_pc", m_pc, 32'h4);
        check_output("small_seq1_pc", {22'b0, s_pc}, 32'h1);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
